// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level round-robin AXI-Stream arbiter.
package axis_arb_pkg;

    // Arbiter FSM: IDLE arbitrates, LOCK holds a grant until the TLAST beat.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Wrap-around increment of a source index in the range 0..n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axis_rr_pkt_arb_rr_pick.sv
// Combinational round-robin priority search: finds the first request at or
// after PTR, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    REQ,
    input  logic [IDXW-1:0] PTR,
    output logic            HIT,
    output logic [IDXW-1:0] IDX
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             offset;
    int             sum;

    // Rotate a doubled request vector so PTR lands at bit 0, then take the
    // lowest set bit and map the offset back to an absolute source index.
    always_comb begin
        req_dbl = {REQ, REQ};
        req_rot = N'(req_dbl >> PTR);
        HIT     = |REQ;
        offset  = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = j;
            end
        end
        sum = int'(PTR) + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        IDX = IDXW'(sum);
    end

endmodule

// File: rtl/axis_rr_pkt_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto one
// NoC injection port. A grant is held from the first beat through TLAST, so
// packets are never interleaved. One arbitration cycle precedes every packet;
// while locked the granted source passes straight through with no buffering.
// Optional build macro ARB_TID_TAG_EN: when defined, M_TID carries the granted
// source index instead of that source's own TID.
module axis_rr_pkt_arb
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int TDATAW  = 32,
    parameter  int TDESTW  = 4,
    parameter  int TIDW    = 2,
    localparam int IDXW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_SRC-1:0]        S_TVALID,
    output logic [NUM_SRC-1:0]        S_TREADY,
    input  logic [NUM_SRC*TDATAW-1:0] S_TDATA,
    input  logic [NUM_SRC-1:0]        S_TLAST,
    input  logic [NUM_SRC*TIDW-1:0]   S_TID,
    input  logic [NUM_SRC*TDESTW-1:0] S_TDEST,
    output logic                      M_TVALID,
    input  logic                      M_TREADY,
    output logic [TDATAW-1:0]         M_TDATA,
    output logic                      M_TLAST,
    output logic [TIDW-1:0]           M_TID,
    output logic [TDESTW-1:0]         M_TDEST,
    output logic                      GRANT_VLD,
    output logic [IDXW-1:0]           GRANT_IDX
);

    arb_state_t      state_q, state_d;
    logic [IDXW-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            pick_hit;
    logic [IDXW-1:0] pick_idx;

    rr_pick #(
        .N    (NUM_SRC),
        .IDXW (IDXW)
    ) u_rr_pick (
        .REQ (S_TVALID),
        .PTR (ptr_q),
        .HIT (pick_hit),
        .IDX (pick_idx)
    );

    // State, grant and priority pointer registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: grab the picked source in IDLE, release after the TLAST beat
    // and move priority to the source just after the one that finished.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    gnt_d   = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (M_TVALID && M_TREADY && M_TLAST) begin
                    state_d = IDLE;
                    ptr_d   = IDXW'(rr_next(int'(gnt_q), NUM_SRC));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: zero outputs in IDLE, transparent mux of the granted source in LOCK.
    always_comb begin
        M_TVALID = 1'b0;
        S_TREADY = '0;
        M_TDATA  = '0;
        M_TLAST  = 1'b0;
        M_TID    = '0;
        M_TDEST  = '0;
        if (state_q == LOCK) begin
            M_TVALID        = S_TVALID[gnt_q];
            S_TREADY[gnt_q] = M_TREADY;
            M_TDATA         = S_TDATA[int'(gnt_q)*TDATAW +: TDATAW];
            M_TLAST         = S_TLAST[gnt_q];
            M_TDEST         = S_TDEST[int'(gnt_q)*TDESTW +: TDESTW];
`ifdef ARB_TID_TAG_EN
            M_TID           = TIDW'(gnt_q);
`else
            M_TID           = S_TID[int'(gnt_q)*TIDW +: TIDW];
`endif
        end
    end

    assign GRANT_VLD = (state_q == LOCK);
    assign GRANT_IDX = gnt_q;

endmodule

// File: tb/tb_axis_rr_pkt_arb.sv
// Randomized self-checking bench for axis_rr_pkt_arb. Sources hold packet
// queues; a packet-level reference model tracks who owns the port and the
// round-robin priority and predicts every output each cycle.
module tb_axis_rr_pkt_arb;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int DESTW = 4;
   localparam int TIDW  = 2;
   localparam int IDXW  = 2;
   localparam int NCYC  = 2000;

   logic              clk = 1'b0;
   logic              rstN = 1'b0;
   logic [N-1:0]      sTvalid;
   logic [N-1:0]      sTready;
   logic [N*DW-1:0]   sTdata;
   logic [N-1:0]      sTlast;
   logic [N*TIDW-1:0] sTid;
   logic [N*DESTW-1:0] sTdest;
   logic              mTvalid;
   logic              mTready;
   logic [DW-1:0]     mTdata;
   logic              mTlast;
   logic [TIDW-1:0]   mTid;
   logic [DESTW-1:0]  mTdest;
   logic              grantVld;
   logic [IDXW-1:0]   grantIdx;

   int total = 0;
   int bad   = 0;

   // Source state: beats remaining in the current packet and the beat on offer.
   int               beatsLeft [N];
   logic [DW-1:0]    curData   [N];
   logic [TIDW-1:0]  curTid    [N];
   logic [DESTW-1:0] curDest   [N];

   // Reference model: owner of the port (-1 when nobody), last grant, priority.
   int owner;
   int lastGrant;
   int prio;

   axis_rr_pkt_arb #(
      .NUM_SRC (N),
      .TDATAW  (DW),
      .TDESTW  (DESTW),
      .TIDW    (TIDW)
   ) dut (
      .CLK       (clk),
      .RST_N     (rstN),
      .S_TVALID  (sTvalid),
      .S_TREADY  (sTready),
      .S_TDATA   (sTdata),
      .S_TLAST   (sTlast),
      .S_TID     (sTid),
      .S_TDEST   (sTdest),
      .M_TVALID  (mTvalid),
      .M_TREADY  (mTready),
      .M_TDATA   (mTdata),
      .M_TLAST   (mTlast),
      .M_TID     (mTid),
      .M_TDEST   (mTdest),
      .GRANT_VLD (grantVld),
      .GRANT_IDX (grantIdx)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Counts a comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drops all source traffic, as an upstream reset would.
   task automatic clearSources();
      for (int i = 0; i < N; i++) begin
         beatsLeft[i] = 0;
         curData[i]   = '0;
         curTid[i]    = '0;
         curDest[i]   = '0;
      end
   endtask

   // Drives the flattened source buses from the per-source state.
   task automatic applyStimulus(input int phase, input int cyc);
      int startPct;
      int validPct;
      bit active;
      startPct = (phase == 0) ? 100 : 40;
      validPct = (phase == 0) ? 100 : 80;
      for (int i = 0; i < N; i++) begin
         active = (phase != 2) || (i == (cyc / 60) % N);
         if (beatsLeft[i] == 0 && active && $urandom_range(0, 99) < startPct) begin
            beatsLeft[i] = (phase == 0) ? 2 : int'($urandom_range(1, 4));
            curData[i]   = $urandom;
            curTid[i]    = TIDW'($urandom);
            curDest[i]   = DESTW'($urandom);
         end
         sTvalid[i] = (beatsLeft[i] > 0) && ($urandom_range(0, 99) < validPct);
         sTlast[i]  = (beatsLeft[i] == 1);
         sTdata[i*DW +: DW]         = curData[i];
         sTid[i*TIDW +: TIDW]       = curTid[i];
         sTdest[i*DESTW +: DESTW]   = curDest[i];
      end
      if (phase == 0)
         mTready = 1'b1;
      else if (phase == 3)
         mTready = ($urandom_range(0, 99) < 30);
      else
         mTready = ($urandom_range(0, 99) < 75);
   endtask

   // Predicts all outputs from the model and compares them with the DUT.
   task automatic compareOutputs();
      logic              eValid;
      logic [N-1:0]      eReady;
      logic [DW-1:0]     eData;
      logic              eLast;
      logic [TIDW-1:0]   eTid;
      logic [DESTW-1:0]  eDest;
      eValid = 1'b0;
      eReady = '0;
      eData  = '0;
      eLast  = 1'b0;
      eTid   = '0;
      eDest  = '0;
      if (owner >= 0) begin
         eValid = sTvalid[owner];
         eReady[owner] = mTready;
         eData  = curData[owner];
         eLast  = (beatsLeft[owner] == 1);
         eDest  = curDest[owner];
`ifdef ARB_TID_TAG_EN
         eTid   = TIDW'(owner);
`else
         eTid   = curTid[owner];
`endif
      end
      checkOutput("grant_vld", 64'(grantVld), 64'(owner >= 0));
      checkOutput("grant_idx", 64'(grantIdx), 64'(lastGrant));
      checkOutput("m_tvalid",  64'(mTvalid),  64'(eValid));
      checkOutput("s_tready",  64'(sTready),  64'(eReady));
      checkOutput("m_tdata",   64'(mTdata),   64'(eData));
      checkOutput("m_tlast",   64'(mTlast),   64'(eLast));
      checkOutput("m_tid",     64'(mTid),     64'(eTid));
      checkOutput("m_tdest",   64'(mTdest),   64'(eDest));
   endtask

   // Advances the model by one clock: consume a beat, release on TLAST, or
   // grant the first valid source at or after the priority index.
   task automatic updateModel();
      bit wasLast;
      int cand;
      if (owner >= 0) begin
         if (sTvalid[owner] && mTready) begin
            wasLast = (beatsLeft[owner] == 1);
            beatsLeft[owner]--;
            curData[owner] = $urandom;
            if (wasLast) begin
               prio  = (owner + 1) % N;
               owner = -1;
            end
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            cand = (prio + k) % N;
            if (sTvalid[cand]) begin
               owner = cand;
            end
         end
         if (owner >= 0) begin
            lastGrant = owner;
         end
      end
   endtask

   // Main sequence: reset check, then phases of full load, random traffic,
   // single active source and heavy back-pressure, with two resets mid-run.
   initial begin
      int phase;
      clearSources();
      sTvalid = '0;
      sTlast  = '0;
      sTdata  = '0;
      sTid    = '0;
      sTdest  = '0;
      mTready = 1'b0;
      owner     = -1;
      lastGrant = 0;
      prio      = 0;
      #2;
      compareOutputs();
      @(posedge clk);
      #1;
      rstN = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         phase = (cyc / 250) % 4;
         applyStimulus(phase, cyc);
         if (cyc == 121 || cyc == 1390) begin
            rstN      = 1'b0;
            owner     = -1;
            lastGrant = 0;
            prio      = 0;
            #1;
         end
         @(negedge clk);
         compareOutputs();
         if (!rstN)
            clearSources();
         else
            updateModel();
         @(posedge clk);
         #1;
         rstN = 1'b1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
